nested_range_gen: RTL and testbench
===================================

NESTED_RANGE_GEN -- requirements
Module: nested_range_gen

Interface
REQ-001 Parameter WIDTH, default 32, signed bit width of every data input and output.
REQ-002 Parameter MODE, default 0, iteration order: 0 = row-major (i outer), 1 = column-major (j outer).
REQ-003 _clock  input  1  sole clock; all state updates on rising edge.
REQ-004 _reset  input  1  synchronous, active-high reset.
REQ-005 _start  input  1  request to begin a run; sampled only in IDLE.
REQ-006 a, b  input  WIDTH signed  outer/inner extents (row count, column count).
REQ-007 c, d  input  WIDTH signed  row stride and column stride.
REQ-008 _ready  input  1  downstream can accept the current tuple.
REQ-009 _out0, _out1  output  WIDTH signed  current tuple: _out0 = i*c, _out1 = j*d.
REQ-010 _valid  output  1  _out0/_out1 hold a tuple to transfer.
REQ-011 _done  output  1  one-cycle pulse marking end of run.

Function
REQ-012 States: IDLE, RUN, DONE; the block SHALL sit in IDLE after reset.
REQ-013 IDLE with _start=1: latch a,b,c,d; if a<=0 or b<=0 go to DONE, else go to RUN with i=j=0.
REQ-014 Inputs a,b,c,d SHALL be ignored after the latching cycle until the next accepted _start.
REQ-015 First _valid SHALL assert the cycle after _start is accepted (latency 1).
REQ-016 RUN: _valid=1; tuple SHALL hold stable until the cycle where _valid and _ready are both 1 (transfer).
REQ-017 On transfer, MODE=0: j increments; at j=b-1 j wraps to 0 and i increments; MODE=1: i increments, at i=a-1 wraps to 0 and j increments.
REQ-018 Transfer of the final tuple (i=a-1, j=b-1) SHALL move to DONE; exactly a*b tuples per run.
REQ-019 _out0/_out1 SHALL be maintained by running accumulators (add c or d, clear on wrap); no multipliers.
REQ-020 Accumulator arithmetic SHALL wrap modulo 2^WIDTH (two's complement); negative strides allowed.
REQ-021 DONE: _done=1, _valid=0 for exactly one cycle, then IDLE.
REQ-022 _start asserted in RUN or DONE SHALL be ignored (not queued).
REQ-023 _ready while _valid=0 SHALL have no effect.
REQ-024 _start and _done in the same cycle: _start ignored; a new run requires _start in IDLE.

Reset
REQ-025 _reset=1 SHALL override all other inputs, including mid-run, and next cycle yield IDLE.
REQ-026 Reset values: _valid=0, _done=0, _out0=0, _out1=0, counters and latched inputs 0.
REQ-027 No tuple in flight at reset SHALL be reported as transferred; no _done pulse from reset.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE/RUN/DONE) and MODE encodings.
REQ-029 One sub-module, range_counter, SHALL implement one index+accumulator pair (count, step, limit, wrap flag); instantiated twice.
REQ-030 Counter widths SHALL equal WIDTH; no other parameter.

Verification
REQ-031 MODE=0, a=2,b=3,c=10,d=1, _ready=1 -> (0,0),(0,1),(0,2),(10,0),(10,1),(10,2) on consecutive cycles, then _done one cycle.
REQ-032 MODE=1, same inputs -> (0,0),(10,0),(0,1),(10,1),(0,2),(10,2), then _done.
REQ-033 a=2,b=2,c=5,d=-3, _ready toggling 1/0 -> (0,0),(0,-3),(5,0),(5,-3), each held while _ready=0, no duplicates/drops.
REQ-034 a=0 (or b=-1), _start -> _valid never asserts, _done pulses the cycle after _start.
REQ-035 _reset after third transfer of REQ-031 run -> next cycle _valid=0, outputs 0, _done=0; fresh _start restarts at (0,0).
REQ-036 WIDTH=8, a=3,b=1,c=100 -> _out0 = 0, 100, -56 (wrap), then _done; _start pulses mid-run ignored.

Source files
------------

// File: rtl/nested_range_gen_pkg.sv
// Shared types for the nested range generator: controller states and
// iteration-order encodings.
package nested_range_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MODE_ROW = 0;  // i outer, j inner
  localparam int MODE_COL = 1;  // j outer, i inner

endpackage

// File: rtl/nested_range_gen_if.sv
// Request/tuple-stream bundle between a producer of run requests and the
// nested range generator. master = requester/consumer side, slave = generator.
interface nested_range_gen_if #(
  parameter int WIDTH = 32
);
  logic                    _start;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic signed [WIDTH-1:0] c;
  logic signed [WIDTH-1:0] d;
  logic                    _ready;
  logic signed [WIDTH-1:0] _out0;
  logic signed [WIDTH-1:0] _out1;
  logic                    _valid;
  logic                    _done;

  modport master (
    output _start, a, b, c, d, _ready,
    input  _out0, _out1, _valid, _done
  );

  modport slave (
    input  _start, a, b, c, d, _ready,
    output _out0, _out1, _valid, _done
  );
endinterface

// File: rtl/nested_range_gen_range_counter.sv
// One loop index with its running accumulator (index*step), wrapping back to
// zero after the index reaches limit-1.
module range_counter #(
  parameter int WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    clr,
  input  logic                    inc,
  input  logic signed [WIDTH-1:0] step,
  input  logic signed [WIDTH-1:0] limit,
  output logic signed [WIDTH-1:0] count,
  output logic signed [WIDTH-1:0] acc,
  output logic                    last,
  output logic                    wrap
);

  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

  logic signed [WIDTH-1:0] count_q, count_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;

  assign last  = (count_q == limit - ONE);
  assign wrap  = inc && last;
  assign count = count_q;
  assign acc   = acc_q;

  // Accumulator adds step per advance instead of multiplying; wraps mod 2^WIDTH.
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (clr) begin
      count_d = '0;
      acc_d   = '0;
    end else if (inc) begin
      if (last) begin
        count_d = '0;
        acc_d   = '0;
      end else begin
        count_d = count_q + ONE;
        acc_d   = acc_q + step;
      end
    end
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/nested_range_gen.sv
// Nested (i,j) range generator streaming (i*c, j*d) with valid/ready.
// States: IDLE wait for start | RUN stream tuples | DONE one-cycle done pulse.
module nested_range_gen
  import nested_range_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = MODE_ROW
) (
  input  logic             _clock,
  input  logic             _reset,
  nested_range_gen_if.slave bus
);

  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

  state_e state_q, state_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

  logic clr;
  logic xfer;
  logic i_inc, j_inc;
  logic i_last, j_last;
  logic i_wrap, j_wrap;
  logic signed [WIDTH-1:0] i_cnt, j_cnt, i_acc, j_acc;

  assign xfer = (state_q == ST_RUN) && bus._ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus._start) begin
          a_d = bus.a;
          b_d = bus.b;
          c_d = bus.c;
          d_d = bus.d;
          clr = 1'b1;
          // Empty ranges skip straight to the done pulse.
          if ((bus.a < ONE) || (bus.b < ONE)) state_d = ST_DONE;
          else                                state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer && i_last && j_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (MODE == MODE_COL) begin
      i_inc = xfer;
      j_inc = xfer && i_last;
    end else begin
      j_inc = xfer;
      i_inc = xfer && j_last;
    end
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  range_counter #(.WIDTH(WIDTH)) u_cnt_i (
    ._clock (_clock),
    ._reset (_reset),
    .clr    (clr),
    .inc    (i_inc),
    .step   (c_q),
    .limit  (a_q),
    .count  (i_cnt),
    .acc    (i_acc),
    .last   (i_last),
    .wrap   (i_wrap)
  );

  range_counter #(.WIDTH(WIDTH)) u_cnt_j (
    ._clock (_clock),
    ._reset (_reset),
    .clr    (clr),
    .inc    (j_inc),
    .step   (d_q),
    .limit  (b_q),
    .count  (j_cnt),
    .acc    (j_acc),
    .last   (j_last),
    .wrap   (j_wrap)
  );

  assign bus._out0  = i_acc;
  assign bus._out1  = j_acc;
  assign bus._valid = (state_q == ST_RUN);
  assign bus._done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_nested_range_gen.sv
// Bench for nested_range_gen: three instances (row-major, column-major, 8-bit)
// checked every cycle against a tuple-list model, plus literal sequences.
module tb_nested_range_gen;
  import nested_range_gen_pkg::*;

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
  } tup_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic   start_v[3];
  logic   ready_v[3];
  longint a_v[3], b_v[3], c_v[3], d_v[3];

  logic [31:0] o0[3], o1[3];
  logic        val[3], dn[3];

  int vectors     = 0;
  int miscompares = 0;

  int   mode_of[3]  = '{MODE_ROW, MODE_COL, MODE_ROW};
  int   width_of[3] = '{32, 32, 8};
  int   phase[3];  // 0 idle, 1 streaming, 2 done pulse
  tup_t exp_q[3][$];

  nested_range_gen_if #(.WIDTH(32)) if0 ();
  nested_range_gen_if #(.WIDTH(32)) if1 ();
  nested_range_gen_if #(.WIDTH(8))  if8 ();

  nested_range_gen #(.WIDTH(32), .MODE(MODE_ROW)) dut0 (._clock(clk), ._reset(rst), .bus(if0));
  nested_range_gen #(.WIDTH(32), .MODE(MODE_COL)) dut1 (._clock(clk), ._reset(rst), .bus(if1));
  nested_range_gen #(.WIDTH(8),  .MODE(MODE_ROW)) dut8 (._clock(clk), ._reset(rst), .bus(if8));

  assign if0._start = start_v[0];
  assign if0._ready = ready_v[0];
  assign if0.a = 32'(a_v[0]);
  assign if0.b = 32'(b_v[0]);
  assign if0.c = 32'(c_v[0]);
  assign if0.d = 32'(d_v[0]);
  assign if1._start = start_v[1];
  assign if1._ready = ready_v[1];
  assign if1.a = 32'(a_v[1]);
  assign if1.b = 32'(b_v[1]);
  assign if1.c = 32'(c_v[1]);
  assign if1.d = 32'(d_v[1]);
  assign if8._start = start_v[2];
  assign if8._ready = ready_v[2];
  assign if8.a = 8'(a_v[2]);
  assign if8.b = 8'(b_v[2]);
  assign if8.c = 8'(c_v[2]);
  assign if8.d = 8'(d_v[2]);

  assign o0[0] = if0._out0;
  assign o1[0] = if0._out1;
  assign val[0] = if0._valid;
  assign dn[0]  = if0._done;
  assign o0[1] = if1._out0;
  assign o1[1] = if1._out1;
  assign val[1] = if1._valid;
  assign dn[1]  = if1._done;
  assign o0[2] = {24'b0, if8._out0};
  assign o1[2] = {24'b0, if8._out1};
  assign val[2] = if8._valid;
  assign dn[2]  = if8._done;

  function automatic logic [31:0] msk(int k);
    return (width_of[k] == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic longint sx(longint v, int k);
    if (width_of[k] == 8) return longint'($signed(v[7:0]));
    return longint'($signed(v[31:0]));
  endfunction

  task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d t=%0t: got %h, want %h", nm, k, $time, act, exp);
    end
  endtask

  // Model: an accepted start expands into the full ordered tuple list.
  task automatic build(int k, longint a, longint b, longint c, longint d);
    tup_t t;
    if (mode_of[k] == MODE_ROW) begin
      for (longint i = 0; i < a; i++)
        for (longint j = 0; j < b; j++) begin
          t.o0 = 32'(i * c);
          t.o1 = 32'(j * d);
          exp_q[k].push_back(t);
        end
    end else begin
      for (longint j = 0; j < b; j++)
        for (longint i = 0; i < a; i++) begin
          t.o0 = 32'(i * c);
          t.o1 = 32'(j * d);
          exp_q[k].push_back(t);
        end
    end
  endtask

  task automatic model_step(int k);
    longint a, b;
    if (rst) begin
      phase[k] = 0;
      exp_q[k].delete();
    end else begin
      case (phase[k])
        0: if (start_v[k]) begin
          a = sx(a_v[k], k);
          b = sx(b_v[k], k);
          exp_q[k].delete();
          if (a <= 0 || b <= 0) phase[k] = 2;
          else begin
            build(k, a, b, sx(c_v[k], k), sx(d_v[k], k));
            phase[k] = 1;
          end
        end
        1: if (ready_v[k]) begin
          void'(exp_q[k].pop_front());
          if (exp_q[k].size() == 0) phase[k] = 2;
        end
        default: phase[k] = 0;
      endcase
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) phase[k] = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check("valid", k, 32'(val[k]), 32'(phase[k] == 1));
      check("done", k, 32'(dn[k]), 32'(phase[k] == 2));
      if (phase[k] == 1 && exp_q[k].size() > 0) begin
        check("out0", k, o0[k] & msk(k), exp_q[k][0].o0 & msk(k));
        check("out1", k, o1[k] & msk(k), exp_q[k][0].o1 & msk(k));
      end
      model_step(k);
    end
  end

  task automatic start_run(bit [2:0] en, longint a, longint b, longint c, longint d);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      if (en[k]) begin
        a_v[k] = a;
        b_v[k] = b;
        c_v[k] = c;
        d_v[k] = d;
        start_v[k] = 1'b1;
      end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (en[k]) start_v[k] = 1'b0;
  endtask

  int          r31_o0[6] = '{0, 0, 0, 10, 10, 10};
  int          r31_o1[6] = '{0, 1, 2, 0, 1, 2};
  int          r32_o0[6] = '{0, 10, 0, 10, 0, 10};
  int          r32_o1[6] = '{0, 0, 1, 1, 2, 2};
  logic [31:0] r33_o0[4] = '{32'd0, 32'd0, 32'd5, 32'd5};
  logic [31:0] r33_o1[4] = '{32'd0, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD};
  logic [31:0] r36_o0[3] = '{32'h00, 32'h64, 32'hC8};
  tup_t        got_q[$];
  tup_t        gt;

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      ready_v[k] = 1'b1;
      a_v[k] = 0; b_v[k] = 0; c_v[k] = 0; d_v[k] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out0", 0, o0[0], 32'd0);
    check("rst_out1", 1, o1[1], 32'd0);

    // Row- and column-major orders side by side, ready held high.
    start_run(3'b011, 2, 3, 10, 1);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("r31_out0", 0, o0[0], 32'(r31_o0[t]));
      check("r31_out1", 0, o1[0], 32'(r31_o1[t]));
      check("r32_out0", 1, o0[1], 32'(r32_o0[t]));
      check("r32_out1", 1, o1[1], 32'(r32_o1[t]));
    end
    @(negedge clk);
    check("r31_done", 0, 32'(dn[0]), 32'd1);
    check("r32_done", 1, 32'(dn[1]), 32'd1);
    @(negedge clk);
    check("r31_done_end", 0, 32'(dn[0]), 32'd0);

    // Negative stride with ready toggling: record only real transfers.
    start_run(3'b001, 2, 2, 5, -3);
    got_q.delete();
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (val[0] && ready_v[0]) begin
        gt.o0 = o0[0];
        gt.o1 = o1[0];
        got_q.push_back(gt);
      end
      @(posedge clk);
      #1 ready_v[0] = ~ready_v[0];
    end
    ready_v[0] = 1'b1;
    check("r33_count", 0, 32'(got_q.size()), 32'd4);
    for (int t = 0; t < 4; t++)
      if (t < got_q.size()) begin
        check("r33_out0", 0, got_q[t].o0, r33_o0[t]);
        check("r33_out1", 0, got_q[t].o1, r33_o1[t]);
      end

    // Empty ranges: done the cycle after start, no valid.
    start_run(3'b001, 0, 3, 1, 1);
    @(negedge clk);
    check("r34a_done", 0, 32'(dn[0]), 32'd1);
    check("r34a_valid", 0, 32'(val[0]), 32'd0);
    @(negedge clk);
    check("r34a_done_end", 0, 32'(dn[0]), 32'd0);
    start_run(3'b001, 2, -1, 1, 1);
    @(negedge clk);
    check("r34b_done", 0, 32'(dn[0]), 32'd1);
    check("r34b_valid", 0, 32'(val[0]), 32'd0);

    // Reset after the third transfer, then a fresh run.
    start_run(3'b001, 2, 3, 10, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("r35_valid", 0, 32'(val[0]), 32'd0);
    check("r35_out0", 0, o0[0], 32'd0);
    check("r35_out1", 0, o1[0], 32'd0);
    check("r35_done", 0, 32'(dn[0]), 32'd0);
    start_run(3'b001, 2, 3, 10, 1);
    @(negedge clk);
    check("r35_restart_valid", 0, 32'(val[0]), 32'd1);
    check("r35_restart_out1", 0, o1[0], 32'd0);
    @(negedge clk);
    check("r35_second_out1", 0, o1[0], 32'd1);
    repeat (8) @(posedge clk);

    // 8-bit wrap with start pulses mid-run and on the done cycle.
    start_run(3'b100, 3, 1, 100, 7);
    @(negedge clk);
    check("r36_out0", 2, o0[2], r36_o0[0]);
    @(posedge clk);
    #1 start_v[2] = 1'b1;
    @(negedge clk);
    check("r36_out0", 2, o0[2], r36_o0[1]);
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    @(negedge clk);
    check("r36_out0", 2, o0[2], r36_o0[2]);
    check("r36_out1", 2, o1[2], 32'd0);
    @(posedge clk);
    #1 start_v[2] = 1'b1;
    @(negedge clk);
    check("r36_done", 2, 32'(dn[2]), 32'd1);
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    @(negedge clk);
    check("r36_idle_valid", 2, 32'(val[2]), 32'd0);
    @(negedge clk);
    check("r36_not_queued", 2, 32'(val[2]), 32'd0);

    // Randomized traffic on all three instances.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 3; k++) begin
        start_v[k] = ($urandom_range(0, 3) == 0);
        ready_v[k] = $urandom_range(0, 1) == 1;
        a_v[k] = longint'($urandom_range(0, 6)) - 1;
        b_v[k] = longint'($urandom_range(0, 6)) - 1;
        c_v[k] = longint'($signed($urandom));
        d_v[k] = longint'($signed($urandom));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      ready_v[k] = 1'b1;
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
